// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared encodings, size decode, default kernels and FSM states for kernel_bank
package kernel_pkg;

    localparam logic [1:0] SIZE_3X3 = 2'b00;
    localparam logic [1:0] SIZE_5X5 = 2'b01;
    localparam logic [1:0] SIZE_7X7 = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    // Kernel edge for a size code; 0 marks the illegal encoding.
    function automatic int size_to_k(input logic [1:0] size);
        case (size)
            SIZE_3X3: return 3;
            SIZE_5X5: return 5;
            SIZE_7X7: return 7;
            default:  return 0;
        endcase
    endfunction

    function automatic int sobel3_coef(input int idx);
        case (idx)
            0, 6:    return 1;
            2, 8:    return -1;
            3:       return 2;
            5:       return -2;
            default: return 0;
        endcase
    endfunction

    function automatic int tab5_coef(input int idx);
        case (idx)
            0, 4, 20, 24:  return 1;
            1, 3, 21, 23:  return 2;
            2, 22:         return 4;
            5, 15:         return 3;
            10, 14:        return 6;
            6, 18:         return -1;
            7, 17:         return -2;
            8, 16:         return -4;
            default:       return 0;
        endcase
    endfunction

    function automatic int alt7_coef(input int idx);
        return (idx % 2 == 0) ? 1 : -1;
    endfunction

    // Reset preload for one storage cell; kernels larger than the store are skipped.
    function automatic int default_coef(input int bank, input int idx, input int max_k);
        case (bank)
            0:       return (max_k >= 3 && idx < 9)  ? sobel3_coef(idx) : 0;
            1:       return (max_k >= 5 && idx < 25) ? tab5_coef(idx)   : 0;
            2:       return (max_k >= 7 && idx < 49) ? alt7_coef(idx)   : 0;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/kernel_bank_rd_fsm.sv
// rtl/kernel_bank_rd_fsm.sv - readout sequencer: state, beat index, last/err generation, registered stream outputs
module kernel_bank_rd_fsm #(
    parameter int COEF_W = 8,
    parameter int MAX_K  = 7,
    parameter int BANK_W = 2,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_start,
    input  logic [BANK_W-1:0]        rd_bank,
    input  logic [1:0]               rd_size,
    input  logic                     rd_ready,
    input  logic signed [COEF_W-1:0] fetch_data,
    output logic [BANK_W-1:0]        fetch_bank,
    output logic [ADDR_W-1:0]        fetch_idx,
    output logic [BANK_W-1:0]        act_bank,
    output logic                     busy,
    output logic                     rd_valid,
    output logic signed [COEF_W-1:0] rd_data,
    output logic [ADDR_W-1:0]        rd_idx,
    output logic                     rd_last,
    output logic                     err
);
    import kernel_pkg::*;

    rd_state_e                state_q, state_d;
    logic [BANK_W-1:0]        bank_q, bank_d;
    logic [ADDR_W-1:0]        last_idx_q, last_idx_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic signed [COEF_W-1:0] data_q, data_d;
    logic                     err_q, err_d;
    logic [ADDR_W-1:0]        idx_inc;
    int                       k;

    assign idx_inc  = idx_q + 1'b1;
    assign act_bank = bank_q;
    assign busy     = (state_q == ST_STREAM);
    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_idx   = idx_q;
    assign rd_last  = last_q;
    assign err      = err_q;

    // State and registered stream outputs; reset aborts any stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bank_q     <= '0;
            last_idx_q <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            last_idx_q <= last_idx_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Next state: the storage is read one beat ahead so rd_data is already registered when valid.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        last_idx_d = last_idx_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        err_d      = 1'b0;
        fetch_bank = bank_q;
        fetch_idx  = idx_inc;
        k          = size_to_k(rd_size);
        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    if (k == 0 || k > MAX_K) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_STREAM;
                        bank_d     = rd_bank;
                        last_idx_d = ADDR_W'(k * k - 1);
                        idx_d      = '0;
                        valid_d    = 1'b1;
                        last_d     = 1'b0;
                        fetch_bank = rd_bank;
                        fetch_idx  = '0;
                        data_d     = fetch_data;
                    end
                end
            end
            ST_STREAM: begin
                if (rd_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_inc;
                        last_d = (idx_inc == last_idx_q);
                        data_d = fetch_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/kernel_bank.sv
// rtl/kernel_bank.sv - multi-bank loadable kernel store with raster readout; KERNEL_BANK_DEFAULTS_EN preloads default kernels at reset
module kernel_bank #(
    parameter int COEF_W    = 8,
    parameter int MAX_K     = 7,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int ADDR_W    = $clog2(MAX_K * MAX_K)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [BANK_W-1:0]        wr_bank,
    input  logic                     wr_first,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     rd_start,
    input  logic [BANK_W-1:0]        rd_bank,
    input  logic [1:0]               rd_size,
    output logic                     busy,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [COEF_W-1:0] rd_data,
    output logic [ADDR_W-1:0]        rd_idx,
    output logic                     rd_last,
    output logic                     err
);
    import kernel_pkg::*;

    localparam int DEPTH = MAX_K * MAX_K;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic signed [COEF_W-1:0] mem [NUM_BANKS][DEPTH];
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        wr_idx;
    logic                     wr_fire;
    logic [BANK_W-1:0]        fetch_bank;
    logic [ADDR_W-1:0]        fetch_idx;
    logic signed [COEF_W-1:0] fetch_data;
    logic [BANK_W-1:0]        act_bank;

    // Loads are held off only for the bank currently being streamed.
    assign wr_ready   = !(busy && (wr_bank == act_bank));
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_idx     = wr_first ? '0 : wr_ptr;
    assign fetch_data = mem[fetch_bank][fetch_idx];

    // Shared load pointer: wr_first restarts a kernel at index 0, wraps at the end of a bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_fire) begin
            wr_ptr <= (wr_idx == LAST_ADDR) ? '0 : wr_idx + 1'b1;
        end
    end

    // Coefficient storage with reset preload (or clear) and single-beat writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
`ifdef KERNEL_BANK_DEFAULTS_EN
                    mem[b][i] <= COEF_W'(default_coef(b, i, MAX_K));
`else
                    mem[b][i] <= '0;
`endif
                end
            end
        end else if (wr_fire) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    kernel_bank_rd_fsm #(
        .COEF_W (COEF_W),
        .MAX_K  (MAX_K),
        .BANK_W (BANK_W),
        .ADDR_W (ADDR_W)
    ) u_rd_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_start   (rd_start),
        .rd_bank    (rd_bank),
        .rd_size    (rd_size),
        .rd_ready   (rd_ready),
        .fetch_data (fetch_data),
        .fetch_bank (fetch_bank),
        .fetch_idx  (fetch_idx),
        .act_bank   (act_bank),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .rd_last    (rd_last),
        .err        (err)
    );

endmodule

// File: tb/tb_kernel_bank.sv
// tb/tb_kernel_bank.sv - directed self-checking bench for kernel_bank
module tb_kernel_bank;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [1:0]        wr_bank = '0;
    logic              wr_first = 1'b0;
    logic signed [7:0] wr_data = '0;
    logic              rd_start = 1'b0;
    logic [1:0]        rd_bank = '0;
    logic [1:0]        rd_size = '0;
    logic              busy;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic signed [7:0] rd_data;
    logic [5:0]        rd_idx;
    logic              rd_last;
    logic              err;

    logic              wr_valid5 = 1'b0;
    logic              wr_ready5;
    logic              rd_start5 = 1'b0;
    logic              busy5;
    logic              rd_valid5;
    logic signed [7:0] rd_data5;
    logic [4:0]        rd_idx5;
    logic              rd_last5;
    logic              err5;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    kernel_bank dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .wr_first(wr_first), .wr_data(wr_data),
        .rd_start(rd_start), .rd_bank(rd_bank), .rd_size(rd_size),
        .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_idx(rd_idx), .rd_last(rd_last), .err(err)
    );

    kernel_bank #(.MAX_K(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_bank(wr_bank),
        .wr_first(wr_first), .wr_data(wr_data),
        .rd_start(rd_start5), .rd_bank(rd_bank), .rd_size(rd_size),
        .busy(busy5), .rd_valid(rd_valid5), .rd_ready(rd_ready),
        .rd_data(rd_data5), .rd_idx(rd_idx5), .rd_last(rd_last5), .err(err5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected coefficient tables: 0 Sobel, 1 5x5 table, 2 alternating, 3 ramp idx-12, 4 zero.
    function automatic int exp_coef(input int tbl, input int idx);
        int sobel [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        int tab5 [25] = '{1, 2, 4, 2, 1,
                          3, -1, -2, -4, 0,
                          6, 0, 0, 0, 6,
                          3, -4, -2, -1, 0,
                          1, 2, 4, 2, 1};
        case (tbl)
            0:       return sobel[idx];
            1:       return tab5[idx];
            2:       return (idx % 2 == 0) ? 1 : -1;
            3:       return idx - 12;
            default: return 0;
        endcase
    endfunction

    task automatic load(input int bank, input int tbl, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_bank  = 2'(bank);
            wr_first = (i == 0);
            wr_data  = 8'(exp_coef(tbl, i));
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wr_first = 1'b0;
    endtask

    // Consume n beats from an already-started stream, checking every sampled cycle.
    task automatic drain(input int n, input int tbl, input bit toggle);
        int beat = 0;
        for (int cyc = 0; cyc < 4 * n + 10 && beat < n; cyc++) begin
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, exp_coef(tbl, beat));
            check("rd_idx", rd_idx, beat);
            check("rd_last", rd_last, (beat == n - 1) ? 1 : 0);
            if (rd_valid && rd_ready) beat++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        check("beat_count", beat, n);
        @(negedge clk);
        check("end_valid", rd_valid, 0);
        check("end_busy", busy, 0);
    endtask

    task automatic start(input int bank, input logic [1:0] size);
        @(posedge clk); #1;
        rd_bank  = 2'(bank);
        rd_size  = size;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_last", rd_last, 0);
        check("rst_data", rd_data, 0);
        check("rst_idx", rd_idx, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifndef KERNEL_BANK_DEFAULTS_EN
        start(0, 2'b00);
        drain(9, 4, 1'b0);
        load(0, 0, 9);
        load(1, 1, 25);
        load(2, 2, 49);
`endif

        // Sobel stream at full rate
        start(0, 2'b00);
        drain(9, 0, 1'b0);

        // Ramp load into bank3 relying on the shared pointer
        load(3, 3, 25);
        start(3, 2'b01);
        drain(25, 3, 1'b0);

        // 7x7 with backpressure every other cycle
        start(2, 2'b10);
        drain(49, 2, 1'b1);

        // Illegal size code
        @(posedge clk); #1;
        rd_size  = 2'b11;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_valid", rd_valid, 0);
        check("err_busy", busy, 0);
        @(negedge clk);
        check("err_one_cycle", err, 0);

        // 7x7 on a store limited to 5x5
        @(posedge clk); #1;
        rd_bank   = 2'd1;
        rd_size   = 2'b10;
        rd_start5 = 1'b1;
        @(posedge clk); #1;
        rd_start5 = 1'b0;
        @(negedge clk);
        check("k5_err", err5, 1);
        check("k5_valid", rd_valid5, 0);
        check("k5_busy", busy5, 0);
        @(negedge clk);
        check("k5_err_one_cycle", err5, 0);
        @(posedge clk); #1;
        rd_size   = 2'b01;
        rd_start5 = 1'b1;
        @(posedge clk); #1;
        rd_start5 = 1'b0;
        @(negedge clk);
        check("k5_legal_busy", busy5, 1);
        check("k5_legal_err", err5, 0);
        repeat (30) @(posedge clk);
        #1;

        // Load port collision during a bank1 stream; restart request ignored
        rd_ready = 1'b0;
        start(1, 2'b01);
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_bank  = 2'd1;
        wr_first = 1'b1;
        wr_data  = 8'sd99;
        @(negedge clk);
        check("busy_stream", busy, 1);
        check("wr_block_same_bank", wr_ready, 0);
        @(posedge clk); #1;
        wr_bank = 2'd0;
        wr_data = 8'sd1;
        @(negedge clk);
        check("wr_other_bank", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_first = 1'b0;
        rd_bank  = 2'd0;
        rd_size  = 2'b00;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        @(negedge clk);
        check("restart_no_err", err, 0);
        check("restart_idx_held", rd_idx, 0);
        @(posedge clk); #1;
        drain(25, 1, 1'b0);

        // Reset in the middle of a 7x7 stream
        start(2, 2'b10);
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_idx", rd_idx, 3);
        rst_n = 1'b0;
        #1;
        check("abort_valid", rd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_last", rd_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_valid) cnt++;
        end
        check("no_resume", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
